// File: rtl/jtpang_pkg.sv
// Shared definitions for the jtpang object path (object DMA and sprite scanner).
package jtpang_pkg;
  localparam int          OBJ_AW   = 9;
  localparam int unsigned OBJ_LAST = 'h1FF;

  typedef enum logic [1:0] {IDLE, REQ, XFER, LAST} obj_st_t;
endpackage

// File: rtl/jtpang_objdma_if.sv
// Z80 bus-master side of the object DMA: bus request/acknowledge and VRAM read path.
interface jtpang_objdma_if
  import jtpang_pkg::*;
#(
  parameter int AW = OBJ_AW
);
  logic          busrq;
  logic          busak_n;
  logic          dma_busy;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_din;

  modport master (output busrq, dma_addr, dma_busy, input busak_n, dma_din);
  modport slave  (input busrq, dma_addr, dma_busy, output busak_n, dma_din);
endinterface

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one clock of latency.
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 9
)(
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);
  logic [DW-1:0] mem [2**AW];

  // Read samples the array before this edge's write lands: same-address collisions return the old byte.
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    q1 <= mem[addr1];
  end
endmodule

// File: rtl/jtpang_objdma.sv
// Object DMA: on a dma_go rising edge takes the Z80 bus and copies LAST+1 VRAM bytes into the object buffer.
// Define JTPANG_DMA_VBL_EN to hold the start of a pending transfer until vertical blank (LVBL low).
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int          AW   = OBJ_AW,
  parameter int unsigned LAST = OBJ_LAST
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            LVBL,
  input  logic            dma_go,
  jtpang_objdma_if.master bus,
  input  logic [AW-1:0]   rd_addr,
  output logic [7:0]      rd_data
);
  localparam logic [AW-1:0] LAST_A = AW'(LAST);

  obj_st_t       r_st, w_st_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt, w_waddr;
  logic          r_busrq, w_busrq_nxt, r_busy, w_busy_nxt, r_first, w_first_nxt;
  logic          r_pend, r_go_l, w_take, w_we, w_start_ok;

`ifdef JTPANG_DMA_VBL_EN
  assign w_start_ok = ~LVBL;
`else
  logic w_unused_lvbl;
  assign w_unused_lvbl = LVBL;
  assign w_start_ok    = 1'b1;
`endif

  // Edge detect runs every clk; a new edge wins over the IDLE consume so no request is lost.
  always_ff @(posedge clk) begin
    r_go_l <= dma_go;
    if (rst)                   r_pend <= 1'b0;
    else if (dma_go & ~r_go_l) r_pend <= 1'b1;
    else if (w_take)           r_pend <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_addr  <= '0;
      r_busrq <= 1'b0;
      r_busy  <= 1'b0;
      r_first <= 1'b0;
    end else if (cen) begin
      r_st    <= w_st_nxt;
      r_addr  <= w_addr_nxt;
      r_busrq <= w_busrq_nxt;
      r_busy  <= w_busy_nxt;
      r_first <= w_first_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_addr_nxt  = r_addr;
    w_busrq_nxt = r_busrq;
    w_busy_nxt  = r_busy;
    w_first_nxt = r_first;
    w_take      = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_addr - AW'(1);
    case (r_st)
      IDLE: if (r_pend && w_start_ok) begin
        w_take      = cen;
        w_st_nxt    = REQ;
        w_addr_nxt  = '0;
        w_busrq_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
        w_first_nxt = 1'b1;
      end
      REQ: if (!bus.busak_n) w_st_nxt = XFER;
      // VRAM data trails the address by one cen, so each step stores the previous address.
      XFER: if (!bus.busak_n) begin
        w_we        = cen & ~rst & ~r_first;
        w_first_nxt = 1'b0;
        if (r_addr == LAST_A) w_st_nxt = jtpang_pkg::LAST;
        else                  w_addr_nxt = r_addr + AW'(1);
      end
      default: if (!bus.busak_n) begin
        w_we        = cen & ~rst;
        w_waddr     = r_addr;
        w_st_nxt    = IDLE;
        w_busrq_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.busrq    = r_busrq;
  assign bus.dma_busy = r_busy;
  assign bus.dma_addr = r_addr;

  jtframe_dual_ram #(.DW(8), .AW(AW)) u_buf (
    .clk   (clk),
    .data0 (bus.dma_din),
    .addr0 (w_waddr),
    .we0   (w_we),
    .addr1 (rd_addr),
    .q1    (rd_data)
  );
endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: VRAM model (byte n = n ^ key), buffer readback via an expected-value queue.
module tb_jtpang_objdma;
  logic       clk = 1'b0;
  logic       rst, cen = 1'b0, LVBL, dma_go;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] vkey;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [8:0] addr;
    logic [7:0] exp;
  } rdvec_t;
  rdvec_t vec[6];

  jtpang_objdma_if #(.AW(9)) bus();

  jtpang_objdma #(.AW(9), .LAST(511)) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .LVBL    (LVBL),
    .dma_go  (dma_go),
    .bus     (bus),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      cen = (cnt == 0);
    end
  end

  // VRAM only answers while the bus is granted; read data appears one cen after the address.
  always @(posedge clk)
    if (cen && !bus.busak_n) bus.dma_din <= bus.dma_addr[7:0] ^ vkey;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step_cen();
    do @(posedge clk); while (!cen);
    @(negedge clk);
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    repeat (2) @(negedge clk);
    dma_go = 1'b0;
  endtask

  task automatic wait_rq(input logic val, input int maxc, output int n);
    n = 0;
    while (bus.busrq !== val && n < maxc) begin
      step_cen();
      n++;
    end
  endtask

  task automatic wait_addr(input logic [8:0] a, input int maxc, output bit ok);
    int n;
    n = 0;
    while (bus.dma_addr !== a && n < maxc) begin
      step_cen();
      n++;
    end
    ok = (bus.dma_addr === a);
  endtask

  task automatic rd(input logic [8:0] a, input logic [7:0] e, input string nm);
    logic [7:0] ex;
    rd_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    ex = exp_q.pop_front();
    chk($sformatf("%s[%0h]", nm, a), 32'(rd_data), 32'(ex));
  endtask

  task automatic rd_range(input int lo, input int hi, input logic [7:0] key, input string nm);
    for (int i = lo; i <= hi; i++) begin
      logic [8:0] a;
      a = 9'(i);
      rd(a, a[7:0] ^ key, nm);
    end
  endtask

  initial begin
    int n;
    bit ok;
    rst = 1'b1; LVBL = 1'b0; dma_go = 1'b0; bus.busak_n = 1'b1; rd_addr = '0; vkey = 8'h5A;
    vec[0] = '{9'h000, 8'h5A};
    vec[1] = '{9'h001, 8'h5B};
    vec[2] = '{9'h07F, 8'h25};
    vec[3] = '{9'h080, 8'hDA};
    vec[4] = '{9'h1FE, 8'hA4};
    vec[5] = '{9'h1FF, 8'hA5};

    repeat (3) @(negedge clk);
    chk("rst_busrq", 32'(bus.busrq), 0);
    chk("rst_busy", 32'(bus.dma_busy), 0);
    chk("rst_addr", 32'(bus.dma_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full pass with a late grant
    pulse_go();
    wait_rq(1'b1, 8, n);
    chk("t1_req_lat", 32'((n <= 2) && bus.busrq), 1);
    chk("t1_busy", 32'(bus.dma_busy), 1);
    repeat (3) step_cen();
    chk("t1_wait_rq", 32'(bus.busrq), 1);
    chk("t1_wait_addr", 32'(bus.dma_addr), 0);
    bus.busak_n = 1'b0;
    n = 0;
    do begin
      step_cen();
      n++;
    end while (bus.busrq && n < 600);
    chk("t1_len", 32'(n), 514);
    chk("t1_busy_end", 32'(bus.dma_busy), 0);
    chk("t1_addr_end", 32'(bus.dma_addr), 32'h1FF);
    for (int i = 0; i < 6; i++) rd(vec[i].addr, vec[i].exp, "t1_vec");
    rd_range(0, 511, 8'h5A, "t1_buf");

    // No grant: must wait in REQ without writing
    vkey = 8'hC3;
    bus.busak_n = 1'b1;
    pulse_go();
    wait_rq(1'b1, 8, n);
    repeat (100) step_cen();
    chk("t2_busrq", 32'(bus.busrq), 1);
    chk("t2_addr", 32'(bus.dma_addr), 0);
    chk("t2_busy", 32'(bus.dma_busy), 1);
    rd(9'h000, 8'h5A, "t2_nowr");
    rd(9'h080, 8'hDA, "t2_nowr");
    rd(9'h1FF, 8'hA5, "t2_nowr");

    // Grant, then pause at 0x080 for 10 cen
    bus.busak_n = 1'b0;
    wait_addr(9'h080, 200, ok);
    chk("t3_reach80", 32'(ok), 1);
    bus.busak_n = 1'b1;
    repeat (10) step_cen();
    chk("t3_hold_addr", 32'(bus.dma_addr), 32'h080);
    chk("t3_hold_rq", 32'(bus.busrq), 1);
    bus.busak_n = 1'b0;
    wait_rq(1'b0, 600, n);
    chk("t3_tail", 32'(n), 385);
    rd_range(0, 511, 8'hC3, "t3_buf");

    // Four dma_go edges mid-pass collapse into one extra pass
    vkey = 8'h3C;
    pulse_go();
    wait_addr(9'h100, 400, ok);
    chk("t4_reach100", 32'(ok), 1);
    for (int i = 0; i < 4; i++) begin
      dma_go = 1'b1;
      repeat (3) @(negedge clk);
      dma_go = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_rq(1'b0, 600, n);
    chk("t4_pass1_end", 32'(bus.busrq), 0);
    chk("t4_busy_gap", 32'(bus.dma_busy), 0);
    step_cen();
    chk("t4_gap_rq", 32'(bus.busrq), 1);
    chk("t4_gap_addr", 32'(bus.dma_addr), 0);
    vkey = 8'h99;
    wait_rq(1'b0, 600, n);
    chk("t4_pass2_len", 32'(n), 514);
    repeat (20) step_cen();
    chk("t4_no_third", 32'(bus.busrq), 0);
    rd_range(0, 511, 8'h99, "t4_buf");

    // Reset mid-transfer at 0x040
    vkey = 8'hA5;
    pulse_go();
    wait_addr(9'h040, 200, ok);
    chk("t5_reach40", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rq_drop", 32'(bus.busrq), 0);
    chk("t5_busy_drop", 32'(bus.dma_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd_range(0, 'h3E, 8'hA5, "t5_new");
    rd_range('h3F, 511, 8'h99, "t5_old");

    // Start gating by vertical blank
    vkey = 8'h17;
    LVBL = 1'b1;
    pulse_go();
`ifdef JTPANG_DMA_VBL_EN
    repeat (20) step_cen();
    chk("t6_hold_vbl", 32'(bus.busrq), 0);
    LVBL = 1'b0;
    wait_rq(1'b1, 4, n);
    chk("t6_rise", 32'(n), 1);
`else
    wait_rq(1'b1, 4, n);
    chk("t6_ignore_vbl", 32'((n <= 2) && bus.busrq), 1);
    LVBL = 1'b0;
`endif
    wait_rq(1'b0, 600, n);
    chk("t6_done", 32'(bus.busrq), 0);
    rd(9'h123, 8'h34, "t6_buf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
